ap_hs_initiator: RTL and testbench

- Host-side master for the ap_ctrl_hs block-level handshake.
- Takes read/write commands on a valid/ready command channel and drives ap_start, addr, wr_data and rd_wr into an ap_ctrl_hs responder (the DUFT wrapper).
- Waits for ap_ready/ap_done, captures ap_return, and returns one response per command on a valid/ready response channel.
- Guards every transaction with a timeout; sits between the test/host controller and the wrapped DUFT.

---
 rtl/ap_hs_pkg.sv | 7 +
 rtl/ap_hs_timer.sv | 18 +
 rtl/ap_hs_initiator.sv | 102 ++++++++++
 tb/tb_ap_hs_initiator.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ap_hs_pkg.sv
// ap_hs_pkg: shared state encoding, command-type codes and default timeout for ap_ctrl_hs masters
package ap_hs_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;
  localparam int DEFAULT_TIMEOUT = 64;
endpackage

// File: rtl/ap_hs_timer.sv
// ap_hs_timer: loadable down-counter; expired_o flags the last enabled cycle of the loaded span
module ap_hs_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= load_val_i;
    else if (en_i && cnt_q != '0) cnt_q <= cnt_q - W'(1);
  assign expired_o = en_i && cnt_q == W'(1);
endmodule

// File: rtl/ap_hs_initiator.sv
// ap_hs_initiator: command/response channel master driving an ap_ctrl_hs responder with timeout guard
module ap_hs_initiator import ap_hs_pkg::*; #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_rd_wr,
  output logic              rsp_timeout,
  output logic              ap_start,
  output logic              rd_wr,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              ap_idle,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic [DATA_W-1:0] ap_return,
  output logic [CNT_W-1:0]  txn_count,
  output logic [CNT_W-1:0]  tmo_count
);
  localparam int TW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  state_e              state_q;
  logic                ap_start_q, rd_wr_q, rsp_valid_q, rsp_rd_wr_q, rsp_timeout_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wr_data_q, rsp_rdata_q;
  logic [CNT_W-1:0]    txn_q, tmo_q;
  logic                accept, expired;
  assign cmd_ready   = state_q == IDLE && ap_idle;
  assign accept      = cmd_valid && cmd_ready;
  assign ap_start    = ap_start_q;
  assign rd_wr       = rd_wr_q;
  assign addr        = addr_q;
  assign wr_data     = wr_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_rd_wr   = rsp_rd_wr_q;
  assign rsp_timeout = rsp_timeout_q;
  assign txn_count   = txn_q;
  assign tmo_count   = tmo_q;
  // a zero load never reaches the expiry value, so TIMEOUT_CYCLES=0 disables the guard
  ap_hs_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (TW'(TIMEOUT_CYCLES)),
    .en_i       (state_q == ISSUE),
    .expired_o  (expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q       <= IDLE;
      ap_start_q    <= 1'b0;
      rd_wr_q       <= 1'b0;
      addr_q        <= '0;
      wr_data_q     <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_rd_wr_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      txn_q         <= '0;
      tmo_q         <= '0;
    end else
      case (state_q)
        IDLE:
          if (accept) begin
            rd_wr_q    <= cmd_rd_wr;
            addr_q     <= cmd_addr;
            wr_data_q  <= cmd_wdata;
            ap_start_q <= 1'b1;
            state_q    <= ISSUE;
          end
        ISSUE: begin
          if (ap_ready) ap_start_q <= 1'b0;
          if (ap_done || expired) begin
            ap_start_q    <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rd_wr_q   <= rd_wr_q;
            rsp_timeout_q <= !ap_done;
            rsp_rdata_q   <= (ap_done && rd_wr_q == RD) ? ap_return : '0;
            txn_q         <= txn_q + CNT_W'(ap_done && !(&txn_q));
            tmo_q         <= tmo_q + CNT_W'(!ap_done && !(&tmo_q));
            state_q       <= RESP;
          end
        end
        RESP:
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_ap_hs_initiator.sv
// tb_ap_hs_initiator: responder model plus scoreboard checking of the ap_ctrl_hs initiator
module tb_ap_hs_initiator;
  import ap_hs_pkg::*;
  localparam int CW = 3;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rd_wr = 0, rsp_valid, rsp_ready = 1, rsp_rd_wr, rsp_timeout;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0, rsp_rdata, addr, wr_data, ap_return;
  logic ap_start, rd_wr, ap_idle, ap_ready, ap_done;
  logic [CW-1:0] txn_count, tmo_count;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;

  ap_hs_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_rd_wr(rsp_rd_wr), .rsp_timeout(rsp_timeout), .ap_start(ap_start),
    .rd_wr(rd_wr), .addr(addr), .wr_data(wr_data), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_return(ap_return), .txn_count(txn_count), .tmo_count(tmo_count));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // responder: read acks start at once and finishes next cycle; write acks one cycle later
  int rs = 0, r_txn = 0, r_wren = 0;
  logic post, hang = 0;
  logic [31:0] rmem [256];
  logic [255:0] rvalid = '0;
  assign ap_idle   = rs == 0 && !post;
  assign ap_ready  = ap_start && ((rs == 0 && rd_wr == RD && !hang) || rs == 1);
  assign ap_done   = rs == 2;
  assign ap_return = rvalid[addr[7:0]] ? rmem[addr[7:0]] : (addr[7:0] == 8'h10 ? 32'hDEADBEEF : 32'h0);
  always @(posedge clk or posedge reset)
    if (reset) begin
      rs <= 0;
      post <= 1;
    end else begin
      post <= 0;
      case (rs)
        0: if (ap_start) rs <= hang ? 3 : (rd_wr == RD ? 2 : 1);
        1: begin rmem[addr[7:0]] <= wr_data; rvalid[addr[7:0]] <= 1'b1; r_wren <= r_wren + 1; rs <= 2; end
        2: begin r_txn <= r_txn + 1; rs <= 0; end
        default: if (!ap_start) rs <= 0;
      endcase
    end

  typedef struct {logic rw; logic tmo; logic [7:0] a; logic [31:0] wd; logic [31:0] rd;} exp_t;
  exp_t sb[$];
  logic [31:0] ref_mem [bit [7:0]];
  int exp_txn = 0, exp_tmo = 0;
  function automatic logic [31:0] ref_rd(input logic [7:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a == 8'h10 ? 32'hDEADBEEF : 32'h0);
  endfunction
  always @(negedge clk or posedge reset)
    if (reset) begin
      sb.delete();
      exp_txn = 0;
      exp_tmo = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.rw = cmd_rd_wr; e.tmo = hang; e.a = cmd_addr[7:0]; e.wd = cmd_wdata;
        e.rd = (cmd_rd_wr == RD && !hang) ? ref_rd(cmd_addr[7:0]) : 32'h0;
        sb.push_back(e);
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_rdata", rsp_rdata, e.rd);
          chk("sb_rd_wr", rsp_rd_wr, e.rw);
          chk("sb_timeout", rsp_timeout, e.tmo);
          if (!e.tmo && e.rw == WR) ref_mem[e.a] = e.wd;
          if (e.tmo) exp_tmo = exp_tmo < 7 ? exp_tmo + 1 : 7;
          else exp_txn = exp_txn < 7 ? exp_txn + 1 : 7;
          chk("sb_txn_count", txn_count, exp_txn);
          chk("sb_tmo_count", tmo_count, exp_tmo);
        end
      end
    end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic rw, input logic [31:0] a, input logic [31:0] d);
    logic acc = 0;
    cmd_valid = 1; cmd_rd_wr = rw; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk); acc = cmd_ready;
      step();
    end
    if (!acc) chk("accept_wait", 0, 1);
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 50 && (sb.size() != 0 || rsp_valid); i++) step();
    if (i == 50) chk("rsp_wait", 0, 1);
  endtask

  initial begin
    int w0, t0, i;
    repeat (3) step();
    chk("rst_ap_start", ap_start, 0); chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_addr", addr, 0); chk("rst_wr_data", wr_data, 0); chk("rst_rd_wr", rd_wr, 0);
    chk("rst_rdata", rsp_rdata, 0); chk("rst_txn", txn_count, 0); chk("rst_tmo", tmo_count, 0);
    reset = 0;
    chk("post_rst_cmd_ready", cmd_ready, 0);
    step();
    chk("idle_cmd_ready", cmd_ready, 1);
    send(RD, 32'h10, 0);
    chk("rd_c1_start", ap_start, 1); chk("rd_c1_addr", addr, 32'h10); chk("rd_c1_rd_wr", rd_wr, 1);
    step();
    chk("rd_c2_start", ap_start, 0); chk("rd_c2_done", ap_done, 1); chk("rd_c2_rsp_valid", rsp_valid, 0);
    step();
    chk("rd_c3_rsp_valid", rsp_valid, 1); chk("rd_c3_start", ap_start, 0);
    chk("rd_c3_rdata", rsp_rdata, 32'hDEADBEEF); chk("rd_c3_rd_wr", rsp_rd_wr, 1);
    chk("rd_c3_timeout", rsp_timeout, 0); chk("rd_c3_txn", txn_count, 1);
    wait_idle();
    w0 = r_wren;
    send(WR, 32'h20, 32'h12345678);
    for (int k = 1; k <= 3; k++) begin
      chk("wr_addr_hold", addr, 32'h20); chk("wr_data_hold", wr_data, 32'h12345678);
      chk("wr_start", ap_start, k < 3); chk("wr_rsp_early", rsp_valid, 0);
      step();
    end
    chk("wr_c4_rsp_valid", rsp_valid, 1); chk("wr_c4_rdata", rsp_rdata, 0);
    chk("wr_wren_pulses", r_wren - w0, 1);
    wait_idle();
    send(RD, 32'h20, 0);
    wait_idle();
    t0 = r_txn;
    for (int k = 0; k < 4; k++) send(k[0] ? RD : WR, 32'h50 + k / 2, 32'hA0 + k);
    wait_idle();
    chk("b2b_txns", r_txn - t0, 4);
    rsp_ready = 0;
    send(RD, 32'h10, 0);
    for (i = 0; i < 20 && !rsp_valid; i++) step();
    if (i == 20) chk("bp_rsp_wait", 0, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", rsp_valid, 1); chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_cmd_ready", cmd_ready, 0);
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_release", rsp_valid, 0); chk("txn_saturated", txn_count, 7);
    hang = 1;
    send(RD, 32'h30, 0);
    for (int k = 1; k <= 8; k++) begin
      chk("tmo_start_held", ap_start, 1); chk("tmo_rsp_early", rsp_valid, 0);
      step();
    end
    chk("tmo_start_drop", ap_start, 0); chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_flag", rsp_timeout, 1); chk("tmo_rdata", rsp_rdata, 0); chk("tmo_count", tmo_count, 1);
    wait_idle();
    hang = 0;
    send(WR, 32'h40, 32'h55);
    step();
    #2 reset = 1;
    #1;
    chk("arst_start", ap_start, 0); chk("arst_addr", addr, 0); chk("arst_wr_data", wr_data, 0);
    chk("arst_rd_wr", rd_wr, 0); chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_txn", txn_count, 0); chk("arst_tmo", tmo_count, 0);
    step(); step();
    reset = 0;
    cmd_valid = 1; cmd_rd_wr = RD; cmd_addr = 32'h20;
    chk("arst_wait_idle", cmd_ready, 0);
    step();
    chk("arst_ready_rise", cmd_ready, 1);
    send(RD, 32'h20, 0);
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
